// File: rtl/joypad_scanner_if.sv
// Board-button side bundle of the joypad scanner: raw buttons in,
// multiplexed P1 pattern and debounced state out.
interface joypad_scanner_if;
  logic [7:0] iButtons;
  logic [5:0] oP;
  logic [7:0] oButtons;
  logic       oChange;

  modport master (output iButtons, input oP, oButtons, oChange);
  modport slave  (input iButtons, output oP, oButtons, oChange);
endinterface

// File: rtl/joypad_scanner.sv
// Synchronises and debounces 8 active-low buttons and time-multiplexes the direction/button
// groups into the P1 pattern. Define JOYPAD_SOCD_FILTER_EN to cancel opposing directions.
module joypad_scanner #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE_MAX = 50000,
  parameter int unsigned SCAN_CYCLES  = 1024
) (
  input  logic            Clock,
  input  logic            Reset,
  joypad_scanner_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIR, S_BTN} state_t;

  logic [7:0]            sync1_q, sync1_d;
  logic [7:0]            sync2_q, sync2_d;
  logic [7:0]            stable_q, stable_d;
  logic [7:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  change_q, change_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      scnt_q, scnt_d;
  logic [5:0]            p_q, p_d;

  logic [3:0] dir;
  logic [3:0] btn;
  logic       dir_act;
  logic       btn_act;
  logic       scan_last;

  always_comb begin
    sync1_d  = bus.iButtons;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    change_d = 1'b0;
    cnt_d    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_MAX - 1)) begin
          stable_d[i] = sync2_q[i];
          change_d    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Groups come from the registered debounced state so the scan sees pre-update values.
  always_comb begin
    dir = stable_q[3:0];
    btn = stable_q[7:4];
`ifdef JOYPAD_SOCD_FILTER_EN
    if (dir[1:0] == 2'b00) dir[1:0] = 2'b11;
    if (dir[3:2] == 2'b00) dir[3:2] = 2'b11;
`endif
    dir_act   = (dir != 4'hF);
    btn_act   = (btn != 4'hF);
    scan_last = (scnt_q == CNT_W'(SCAN_CYCLES - 1));
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (dir_act)      state_d = S_DIR;
        else if (btn_act) state_d = S_BTN;
      end
      S_DIR: begin
        if (!dir_act && !btn_act)     state_d = S_IDLE;
        else if (!dir_act)            state_d = S_BTN;
        else if (scan_last && btn_act) state_d = S_BTN;
        else if (!scan_last)          scnt_d  = scnt_q + CNT_W'(1);
      end
      S_BTN: begin
        if (!dir_act && !btn_act)     state_d = S_IDLE;
        else if (!btn_act)            state_d = S_DIR;
        else if (scan_last && dir_act) state_d = S_DIR;
        else if (!scan_last)          scnt_d  = scnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Pattern follows the state being entered, so it lands in step with the state register.
    case (state_d)
      S_DIR:   p_d = {2'b10, dir};
      S_BTN:   p_d = {2'b01, btn};
      default: p_d = 6'h3F;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      cnt_q    <= '0;
      change_q <= 1'b0;
      state_q  <= S_IDLE;
      scnt_q   <= '0;
      p_q      <= 6'h3F;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      p_q      <= p_d;
    end
  end

  assign bus.oP       = p_q;
  assign bus.oButtons = stable_q;
  assign bus.oChange  = change_q;

endmodule

// File: tb/tb_joypad_scanner.sv
// Directed bench for joypad_scanner with DEBOUNCE_MAX=4, SCAN_CYCLES=8.
module tb_joypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  joypad_scanner_if bus ();

  joypad_scanner #(.CNT_W(16), .DEBOUNCE_MAX(4), .SCAN_CYCLES(8)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] btn;
    logic [5:0] p;
    logic [7:0] ob;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] P_IDLE = 6'h3F;
  localparam logic [5:0] P_DIR_R = 6'b101110;
  localparam logic [5:0] P_BTN_ST = 6'b010111;
  localparam logic [5:0] P_BTN_A = 6'b011110;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic [7:0] b, input logic [5:0] p,
                      input logic [7:0] ob, input logic c, input int n);
    vec_t v;
    v.rst_n = r; v.btn = b; v.p = p; v.ob = ob; v.chg = c;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    logic [5:0] exp_p;
    bus.iButtons = 8'h00;
    rst_n = 1'b0;

    // reset held with all buttons low
    addv(1'b0, 8'h00, P_IDLE, 8'hFF, 1'b0, 3);
    // A pressed: accepted on 6th edge, oP on 7th
    addv(1'b1, 8'hEF, P_IDLE, 8'hFF, 1'b0, 5);
    addv(1'b1, 8'hEF, P_IDLE, 8'hEF, 1'b1, 1);
    addv(1'b1, 8'hEF, P_BTN_A, 8'hEF, 1'b0, 3);
    // release A
    addv(1'b1, 8'hFF, P_BTN_A, 8'hEF, 1'b0, 5);
    addv(1'b1, 8'hFF, P_BTN_A, 8'hFF, 1'b1, 1);
    addv(1'b1, 8'hFF, P_IDLE, 8'hFF, 1'b0, 1);
    // 3-cycle glitch on Right is rejected
    addv(1'b1, 8'hFE, P_IDLE, 8'hFF, 1'b0, 3);
    addv(1'b1, 8'hFF, P_IDLE, 8'hFF, 1'b0, 5);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      bus.iButtons = vecs[i].btn;
      tick();
      chk($sformatf("vec%0d.oP", i), 32'(bus.oP), 32'(vecs[i].p));
      chk($sformatf("vec%0d.oButtons", i), 32'(bus.oButtons), 32'(vecs[i].ob));
      chk($sformatf("vec%0d.oChange", i), 32'(bus.oChange), 32'(vecs[i].chg));
    end

    // Right+Start: alternate DIR/BTN, 8 cycles each
    bus.iButtons = 8'h7E;
    for (int k = 1; k <= 6; k++) tick();
    chk("scan.oButtons", 32'(bus.oButtons), 32'h7E);
    chk("scan.oChange", 32'(bus.oChange), 32'h1);
    for (int k = 0; k < 32; k++) begin
      tick();
      exp_p = ((k / 8) % 2 == 0) ? P_DIR_R : P_BTN_ST;
      chk($sformatf("scan.oP[%0d]", k), 32'(bus.oP), 32'(exp_p));
    end
    bus.iButtons = 8'hFF;
    for (int k = 1; k <= 6; k++) tick();
    chk("scan_rel.oButtons", 32'(bus.oButtons), 32'hFF);
    chk("scan_rel.oChange", 32'(bus.oChange), 32'h1);
    tick();
    chk("scan_rel.oP", 32'(bus.oP), 32'(P_IDLE));

    // reset pulse mid-scan, then full re-debounce
    bus.iButtons = 8'h7E;
    for (int k = 1; k <= 10; k++) tick();
    chk("midscan.oP", 32'(bus.oP), 32'(P_DIR_R));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst.oP", 32'(bus.oP), 32'(P_IDLE));
    chk("rst.oButtons", 32'(bus.oButtons), 32'hFF);
    chk("rst.oChange", 32'(bus.oChange), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("redeb.oButtons[%0d]", k), 32'(bus.oButtons), 32'hFF);
      chk($sformatf("redeb.oP[%0d]", k), 32'(bus.oP), 32'(P_IDLE));
    end
    tick();
    chk("redeb.oButtons", 32'(bus.oButtons), 32'h7E);
    chk("redeb.oChange", 32'(bus.oChange), 32'h1);
    tick();
    chk("redeb.oP", 32'(bus.oP), 32'(P_DIR_R));

    // Left+Right together
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.iButtons = 8'hFC;
    for (int k = 1; k <= 6; k++) tick();
    chk("socd.oButtons", 32'(bus.oButtons), 32'hFC);
`ifdef JOYPAD_SOCD_FILTER_EN
    exp_p = 6'h3F;
`else
    exp_p = 6'b101100;
`endif
    tick();
    chk("socd.oP", 32'(bus.oP), 32'(exp_p));
    tick();
    chk("socd.oP_hold", 32'(bus.oP), 32'(exp_p));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
